display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter: DIV_TICKS, default 100000, meaning clock cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 Parameter: BLANK_LZ, default 1, meaning 1 blanks leading zeros and 0 shows all four digits.
REQ-003 Port: clock, input, 1 bit, single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port: reset, input, 1 bit, asynchronous active-high reset.
REQ-005 Port: control, input, 1 bit, source select: 1 = frecuencia, 0 = corriente.
REQ-006 Port: frecuencia, input, 8 bits, unsigned binary value.
REQ-007 Port: corriente, input, 10 bits, unsigned binary value.
REQ-008 Port: selec_digito, output, 2 bits, index of the active digit (0 = units, 3 = thousands).
REQ-009 Port: anodos, output, 4 bits, active-low digit enables; exactly one bit is low when not blanked.
REQ-010 Port: num, output, 4 bits, BCD digit sent to the segment-code memory.
REQ-011 Port: conv_done, output, 1 bit, one-cycle pulse marking that the display register was updated.

Function
REQ-012 Converter FSM states SHALL be LOAD, SHIFT and UPDATE, running continuously.
REQ-013 LOAD (1 cycle) SHALL sample the selected source (frecuencia zero-extended to 10 bits when control=1, else corriente) into a 10-bit shift register, clear a 16-bit BCD accumulator and clear the bit counter, then go to SHIFT.
REQ-014 SHIFT (exactly 10 cycles) SHALL, each cycle, add 3 to every BCD nibble >= 5 and then shift {BCD, binary} left by one; after the 10th shift it SHALL go to UPDATE.
REQ-015 UPDATE (1 cycle) SHALL copy the accumulator into a 16-bit display register, pulse conv_done high, and return to LOAD; the conversion period is therefore 12 cycles.
REQ-016 The display register SHALL change only in UPDATE, so a scan slot never shows a partially converted value.
REQ-017 A change of control or input data in mid-conversion SHALL NOT affect the conversion in progress; it takes effect at the next LOAD.
REQ-018 Scan divider: a counter SHALL count 0..DIV_TICKS-1 and wrap; at wrap it issues a one-cycle tick.
REQ-019 On each tick, selec_digito SHALL advance 0->1->2->3->0 (modulo-4 wrap), and anodos and num SHALL update on the same edge.
REQ-020 anodos SHALL equal ~(4'b0001 << selec_digito), and num SHALL be display-register nibble [4*selec_digito +: 4].
REQ-021 With BLANK_LZ=1, digit k>0 SHALL be blanked (anodos=4'b1111, num=0) when it and every higher digit are zero; digit 0 is never blanked.
REQ-022 Maximum value 1023 SHALL display as 1,0,2,3; a thousands digit above 1 is unreachable.
REQ-023 When a tick and UPDATE fall on the same cycle, the registered outputs SHALL use the pre-update display register; the new value appears from the next tick.

Reset
REQ-024 Reset assertion SHALL immediately force: FSM=LOAD, divider=0, selec_digito=0, anodos=4'b1111, num=0, conv_done=0, display register=0, accumulator=0.
REQ-025 After reset release, the first LOAD SHALL occur on the first clock edge, and the first tick SHALL occur DIV_TICKS cycles later, enabling digit 0.
REQ-026 Reset asserted in mid-conversion or mid-slot SHALL discard the partial result; no conv_done pulse is produced for it.

Verification
REQ-027 control=0, corriente=1023, DIV_TICKS=4 -> conv_done 12 cycles after release; digit scan shows num 3,2,0,1 with anodos 1110,1101,1011,0111.
REQ-028 control=1, frecuencia=8'd7, BLANK_LZ=1 -> digit 0 shows num=7 with anodos=1110; digits 1-3 show anodos=1111.
REQ-029 Switch control from 0 to 1 (corriente=500, frecuencia=255) at SHIFT cycle 5 -> the next UPDATE holds 0500; the following UPDATE holds 0255.
REQ-030 Scan wrap: run 8 ticks -> selec_digito sequence 0,1,2,3,0,1,2,3 with no skipped or repeated slot; tick spacing is exactly DIV_TICKS cycles.
REQ-031 Assert reset in the middle of SHIFT while digit 2 is active -> outputs immediately show anodos=1111, num=0; no conv_done pulse until 12 cycles after release.
REQ-032 Input 0 with BLANK_LZ=0 -> all four digits show num=0, with every anode enabled in turn.

Source files
------------

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display driver: converts a 10-bit binary source to BCD
// with a shift-add-3 FSM and scans the converted digits onto common-anode outputs.
module display_scan_controller #(
    parameter int unsigned DIV_TICKS = 100000,
    parameter int unsigned BLANK_LZ  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       control,
    input  logic [7:0] frecuencia,
    input  logic [9:0] corriente,
    output logic [1:0] selec_digito,
    output logic [3:0] anodos,
    output logic [3:0] num,
    output logic       conv_done
);

    localparam int unsigned BIN_W    = 10;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned BITCNT_W = 4;
    localparam int unsigned CNT_W    = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;

    localparam logic [CNT_W-1:0]    DIV_LAST   = CNT_W'(DIV_TICKS - 1);
    localparam logic [BITCNT_W-1:0] LAST_SHIFT = BITCNT_W'(BIN_W - 1);
    localparam logic                BLANK_EN   = (BLANK_LZ != 0);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } conv_state_t;

    conv_state_t state_q;
    conv_state_t state_d;

    // Converter datapath registers
    logic [BIN_W-1:0]    bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BITCNT_W-1:0] bit_cnt_q;
    logic [BCD_W-1:0]    disp_q;

    // Scan registers
    logic [CNT_W-1:0] div_q;
    logic [1:0]       next_dig_q;

    // Combinational helpers
    logic              load_en_c;
    logic              shift_en_c;
    logic              update_en_c;
    logic [BIN_W-1:0]  src_c;
    logic [BCD_W-1:0]  bcd_adj_c;
    logic [BCD_W-1:0]  bcd_shift_c;
    logic [BIN_W-1:0]  bin_shift_c;
    logic              tick_c;
    logic [DIGITS-1:0] dig_zero_c;
    logic [DIGITS-1:0] lead_zero_c;
    logic              slot_blank_c;
    logic [3:0]        slot_nib_c;
    logic [3:0]        slot_anodos_c;
    logic [3:0]        slot_num_c;

    // Converter state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter next-state and phase strobes
    always_comb begin
        state_d     = state_q;
        load_en_c   = 1'b0;
        shift_en_c  = 1'b0;
        update_en_c = 1'b0;
        case (state_q)
            LOAD: begin
                load_en_c = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                shift_en_c = 1'b1;
                if (bit_cnt_q == LAST_SHIFT) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                update_en_c = 1'b1;
                state_d     = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Source select; only consumed in LOAD so mid-conversion changes are ignored
    always_comb begin
        src_c = corriente;
        if (control) begin
            src_c = {2'b00, frecuencia};
        end
    end

    // Add-3 correction on every BCD nibble that would overflow after doubling
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[i*NIB_W +: NIB_W] >= 4'd5) begin
                bcd_adj_c[i*NIB_W +: NIB_W] = 4'(bcd_q[i*NIB_W +: NIB_W] + 4'd3);
            end
        end
    end

    // Joint left shift of the corrected BCD accumulator and the binary operand
    always_comb begin
        bcd_shift_c = {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_shift_c = {bin_q[BIN_W-2:0], 1'b0};
    end

    // Converter datapath: sample, shift, publish
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            disp_q    <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= update_en_c;
            if (load_en_c) begin
                bin_q     <= src_c;
                bcd_q     <= '0;
                bit_cnt_q <= '0;
            end
            if (shift_en_c) begin
                bin_q     <= bin_shift_c;
                bcd_q     <= bcd_shift_c;
                bit_cnt_q <= BITCNT_W'(bit_cnt_q + BITCNT_W'(1));
            end
            if (update_en_c) begin
                disp_q <= bcd_q;
            end
        end
    end

    assign tick_c = (div_q == DIV_LAST);

    // Slot divider: free-running 0..DIV_TICKS-1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= CNT_W'(div_q + CNT_W'(1));
        end
    end

    // Leading-zero detection across the published display value
    always_comb begin
        dig_zero_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig_zero_c[i] = (disp_q[i*NIB_W +: NIB_W] == 4'd0);
        end
        lead_zero_c    = '0;
        lead_zero_c[3] = dig_zero_c[3];
        lead_zero_c[2] = lead_zero_c[3] & dig_zero_c[2];
        lead_zero_c[1] = lead_zero_c[2] & dig_zero_c[1];
        lead_zero_c[0] = 1'b0;
    end

    // Digit about to be shown on the next tick, with optional blanking
    always_comb begin
        slot_nib_c    = disp_q[{next_dig_q, 2'b00} +: NIB_W];
        slot_blank_c  = BLANK_EN & lead_zero_c[next_dig_q];
        slot_anodos_c = ~(4'b0001 << next_dig_q);
        slot_num_c    = slot_nib_c;
        if (slot_blank_c) begin
            slot_anodos_c = 4'b1111;
            slot_num_c    = 4'd0;
        end
    end

    // Scan outputs advance only on tick; the first tick after reset shows digit 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_dig_q   <= 2'd0;
            selec_digito <= 2'd0;
            anodos       <= 4'b1111;
            num          <= 4'd0;
        end else if (tick_c) begin
            next_dig_q   <= 2'(next_dig_q + 2'd1);
            selec_digito <= next_dig_q;
            anodos       <= slot_anodos_c;
            num          <= slot_num_c;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a short slot period.
module tb_display_scan_controller;

    logic       clock;
    logic       reset;
    logic       control;
    logic [7:0] frecuencia;
    logic [9:0] corriente;
    logic [1:0] selec_digito;
    logic [3:0] anodos;
    logic [3:0] num;
    logic       conv_done;
    logic [1:0] nb_selec_digito;
    logic [3:0] nb_anodos;
    logic [3:0] nb_num;
    logic       nb_conv_done;

    int checks;
    int failures;
    int edge_n;

    display_scan_controller #(.DIV_TICKS(4), .BLANK_LZ(1)) dut (
        .clock(clock), .reset(reset), .control(control),
        .frecuencia(frecuencia), .corriente(corriente),
        .selec_digito(selec_digito), .anodos(anodos), .num(num),
        .conv_done(conv_done)
    );

    display_scan_controller #(.DIV_TICKS(4), .BLANK_LZ(0)) dut_nb (
        .clock(clock), .reset(reset), .control(control),
        .frecuencia(frecuencia), .corriente(corriente),
        .selec_digito(nb_selec_digito), .anodos(nb_anodos), .num(nb_num),
        .conv_done(nb_conv_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout edge=%0d", edge_n);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    // Release lands 1 time unit after a rising edge; the next edge is edge 1
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (anodos !== 4'b1111 || num !== 4'd0 || selec_digito !== 2'd0 || conv_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got an=%b num=%0d sel=%0d cd=%b exp an=1111 num=0 sel=0 cd=0",
                     anodos, num, selec_digito, conv_done);
        end
        reset  = 1'b0;
        edge_n = 0;
        for (int e = 1; e <= 4; e++) begin
            logic [3:0] exp_an;
            step();
            exp_an = (e == 4) ? 4'b1110 : 4'b1111;
            checks++;
            if (anodos !== exp_an || selec_digito !== 2'd0) begin
                failures++;
                $display("FAIL reset_first_tick e=%0d got an=%b sel=%0d exp an=%b sel=0",
                         e, anodos, selec_digito, exp_an);
            end
        end
    endtask

    task automatic test_max();
        logic [1:0] exp_sel [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [3:0] exp_an  [8] = '{4'b1110, 4'b1111, 4'b1111, 4'b0111,
                                    4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exp_num [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 4'd2, 4'd0, 4'd1};
        control   = 1'b0;
        corriente = 10'd1023;
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            logic exp_cd;
            step();
            exp_cd = (e == 12 || e == 24);
            checks++;
            if (conv_done !== exp_cd) begin
                failures++;
                $display("FAIL max_conv_done e=%0d got=%b exp=%b", e, conv_done, exp_cd);
            end
            if (e % 4 == 0) begin
                int t;
                t = e / 4 - 1;
                checks++;
                if (selec_digito !== exp_sel[t] || anodos !== exp_an[t] || num !== exp_num[t]) begin
                    failures++;
                    $display("FAIL max_tick t=%0d got sel=%0d an=%b num=%0d exp sel=%0d an=%b num=%0d",
                             t, selec_digito, anodos, num, exp_sel[t], exp_an[t], exp_num[t]);
                end
            end
        end
    endtask

    task automatic test_scan_wrap();
        control   = 1'b0;
        corriente = 10'd1023;
        do_reset();
        for (int e = 1; e <= 36; e++) begin
            logic [1:0] exp_sel;
            logic [3:0] exp_an;
            step();
            if (e < 4) exp_sel = 2'd0;
            else       exp_sel = 2'((e / 4 - 1) % 4);
            exp_an = ~(4'b0001 << exp_sel);
            checks++;
            if (selec_digito !== exp_sel) begin
                failures++;
                $display("FAIL wrap_sel e=%0d got=%0d exp=%0d", e, selec_digito, exp_sel);
            end
            if (e >= 16) begin
                checks++;
                if (anodos !== exp_an) begin
                    failures++;
                    $display("FAIL wrap_anodos e=%0d got=%b exp=%b", e, anodos, exp_an);
                end
            end
        end
    endtask

    task automatic test_small();
        logic [3:0] exp_an  [8] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111,
                                    4'b1110, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0] exp_num [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0};
        control    = 1'b1;
        frecuencia = 8'd7;
        corriente  = 10'd999;
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e >= 16 && e % 4 == 0) begin
                int t;
                t = e / 4 - 1;
                checks++;
                if (anodos !== exp_an[t] || num !== exp_num[t]) begin
                    failures++;
                    $display("FAIL small_tick t=%0d got an=%b num=%0d exp an=%b num=%0d",
                             t, anodos, num, exp_an[t], exp_num[t]);
                end
            end
        end
    endtask

    // Ticks at edges 16,20,24,28 show digits 3,0,1,2 of the first conversion
    task automatic test_values();
        logic [9:0] vals [3]    = '{10'd999, 10'd100, 10'd5};
        logic [3:0] exp_an [12] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011,
                                    4'b1111, 4'b1110, 4'b1101, 4'b1011,
                                    4'b1111, 4'b1110, 4'b1111, 4'b1111};
        logic [3:0] exp_num [12] = '{4'd0, 4'd9, 4'd9, 4'd9,
                                     4'd0, 4'd0, 4'd0, 4'd1,
                                     4'd0, 4'd5, 4'd0, 4'd0};
        control = 1'b0;
        for (int v = 0; v < 3; v++) begin
            corriente = vals[v];
            do_reset();
            for (int e = 1; e <= 28; e++) begin
                step();
                if (e >= 16 && e % 4 == 0) begin
                    int k;
                    k = v * 4 + (e - 16) / 4;
                    checks++;
                    if (anodos !== exp_an[k] || num !== exp_num[k]) begin
                        failures++;
                        $display("FAIL values v=%0d e=%0d got an=%b num=%0d exp an=%b num=%0d",
                                 vals[v], e, anodos, num, exp_an[k], exp_num[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_switch();
        logic [1:0] exp_sel [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_an  [10] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1110,
                                     4'b1101, 4'b1011, 4'b1111, 4'b1110, 4'b1101};
        logic [3:0] exp_num [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd5, 4'd5};
        control    = 1'b0;
        corriente  = 10'd500;
        frecuencia = 8'd255;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            logic exp_cd;
            step();
            if (e == 6) control = 1'b1;
            exp_cd = (e == 12 || e == 24 || e == 36);
            checks++;
            if (conv_done !== exp_cd) begin
                failures++;
                $display("FAIL switch_conv_done e=%0d got=%b exp=%b", e, conv_done, exp_cd);
            end
            if (e % 4 == 0) begin
                int t;
                t = e / 4 - 1;
                checks++;
                if (selec_digito !== exp_sel[t] || anodos !== exp_an[t] || num !== exp_num[t]) begin
                    failures++;
                    $display("FAIL switch_tick t=%0d got sel=%0d an=%b num=%0d exp sel=%0d an=%b num=%0d",
                             t, selec_digito, anodos, num, exp_sel[t], exp_an[t], exp_num[t]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        control   = 1'b0;
        corriente = 10'd1023;
        do_reset();
        for (int e = 1; e <= 30; e++) step();
        checks++;
        if (anodos !== 4'b1011 || selec_digito !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_pre got an=%b sel=%0d exp an=1011 sel=2", anodos, selec_digito);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (anodos !== 4'b1111 || num !== 4'd0 || selec_digito !== 2'd0 || conv_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_immediate got an=%b num=%0d sel=%0d cd=%b exp an=1111 num=0 sel=0 cd=0",
                     anodos, num, selec_digito, conv_done);
        end
        step();
        step();
        reset  = 1'b0;
        edge_n = 0;
        for (int e = 1; e <= 13; e++) begin
            logic exp_cd;
            step();
            exp_cd = (e == 12);
            checks++;
            if (conv_done !== exp_cd) begin
                failures++;
                $display("FAIL rstmid_conv_done e=%0d got=%b exp=%b", e, conv_done, exp_cd);
            end
        end
    endtask

    task automatic test_zero_noblank();
        control   = 1'b0;
        corriente = 10'd0;
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e % 4 == 0) begin
                logic [1:0] exp_sel;
                logic [3:0] exp_an;
                logic [3:0] exp_bl_an;
                exp_sel   = 2'((e / 4 - 1) % 4);
                exp_an    = ~(4'b0001 << exp_sel);
                exp_bl_an = (exp_sel == 2'd0) ? 4'b1110 : 4'b1111;
                checks++;
                if (nb_selec_digito !== exp_sel || nb_anodos !== exp_an || nb_num !== 4'd0) begin
                    failures++;
                    $display("FAIL zero_noblank e=%0d got sel=%0d an=%b num=%0d exp sel=%0d an=%b num=0",
                             e, nb_selec_digito, nb_anodos, nb_num, exp_sel, exp_an);
                end
                checks++;
                if (anodos !== exp_bl_an || num !== 4'd0) begin
                    failures++;
                    $display("FAIL zero_blank e=%0d got an=%b num=%0d exp an=%b num=0",
                             e, anodos, num, exp_bl_an);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        edge_n     = 0;
        reset      = 1'b1;
        control    = 1'b0;
        frecuencia = 8'd0;
        corriente  = 10'd0;
        test_reset();
        test_max();
        test_scan_wrap();
        test_small();
        test_values();
        test_switch();
        test_reset_mid();
        test_zero_noblank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
